axi_lite_seq_master: RTL and testbench

- Synthesizable AXI4-Lite command sequencer. Replays queued register writes, reads and poll-until-match operations on an AXI4-Lite master port.
- Replaces hand-driven bring-up of the tpm_ip register map with an on-chip engine. Driven by a PS-side or microcode command source.
- Parametrised in address/data width, command queue depth, poll limit and handshake timeout.
- Adds read-compare polling and timeout recovery.

---
 rtl/axi_lite_seq_master.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_seq_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_seq_master.sv
// rtl/axi_lite_seq_master.sv - AXI4-Lite command sequencer: queued write/read/poll with timeout recovery

module axi_lite_seq_master_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module axi_lite_seq_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 8,
    parameter int POLL_LIMIT     = 255,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    m00_axi_aclk,
    input  logic                    m00_axi_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [DATA_WIDTH-1:0]   cmd_mask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_status,
    output logic                    busy,
    output logic                    error,
    output logic [ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]              m00_axi_awprot,
    output logic                    m00_axi_awvalid,
    input  logic                    m00_axi_awready,
    output logic [DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                    m00_axi_wvalid,
    input  logic                    m00_axi_wready,
    input  logic [1:0]              m00_axi_bresp,
    input  logic                    m00_axi_bvalid,
    output logic                    m00_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]              m00_axi_arprot,
    output logic                    m00_axi_arvalid,
    input  logic                    m00_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]              m00_axi_rresp,
    input  logic                    m00_axi_rvalid,
    output logic                    m00_axi_rready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CMD_WIDTH  = 2 + ADDR_WIDTH + 2 * DATA_WIDTH + STRB_WIDTH;
    localparam int POLL_W     = (POLL_LIMIT < 1) ? 1 : $clog2(POLL_LIMIT + 1);
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_LIMIT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_POLL    = 2'b10;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BUS_ERR = 2'b01;
    localparam logic [1:0] ST_POLL_EX = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RSP
    } state_t;

    state_t state;
    state_t state_next;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [CMD_WIDTH-1:0]  fifo_head;
    logic [1:0]            head_op;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic [STRB_WIDTH-1:0] head_wstrb;
    logic [DATA_WIDTH-1:0] head_mask;

    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0] mask_q;
    logic                  aw_done;
    logic                  w_done;
    logic [POLL_W-1:0]     poll_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [1:0]            rsp_status_q;
    logic                  error_q;

    logic       status_load;
    logic [1:0] status_set;
    logic       rdata_load;
    logic       poll_inc;
    logic       tmo_hit;
    logic       poll_match;
    logic       wait_state;

    axi_lite_seq_master_cmd_fifo #(
        .WIDTH(CMD_WIDTH),
        .DEPTH(CMD_DEPTH)
    ) u_cmd_fifo (
        .clk      (m00_axi_aclk),
        .reset    (m00_axi_areset),
        .push     (cmd_valid && cmd_ready),
        .push_data({cmd_op, cmd_addr, cmd_wdata, cmd_wstrb, cmd_mask}),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign {head_op, head_addr, head_wdata, head_wstrb, head_mask} = fifo_head;

    assign cmd_ready      = !fifo_full;
    assign busy           = !fifo_empty || (state != S_IDLE);
    assign rsp_data       = rsp_data_q;
    assign rsp_status     = rsp_status_q;
    assign error          = error_q;
    assign m00_axi_awaddr = addr_q;
    assign m00_axi_araddr = addr_q;
    assign m00_axi_wdata  = wdata_q;
    assign m00_axi_wstrb  = wstrb_q;
    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;

    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign poll_match = ((m00_axi_rdata ^ wdata_q) & mask_q) == '0;
    assign wait_state = (state == S_WR) || (state == S_WR_RESP) ||
                        (state == S_RD_ADDR) || (state == S_RD_DATA);

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        fifo_pop        = 1'b0;
        m00_axi_awvalid = 1'b0;
        m00_axi_wvalid  = 1'b0;
        m00_axi_bready  = 1'b0;
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;
        rsp_valid       = 1'b0;
        status_load     = 1'b0;
        status_set      = ST_OK;
        rdata_load      = 1'b0;
        poll_inc        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = (head_op == OP_WRITE) ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                m00_axi_awvalid = !aw_done;
                m00_axi_wvalid  = !w_done;
                if ((aw_done || m00_axi_awready) && (w_done || m00_axi_wready)) begin
                    state_next = S_WR_RESP;
                end else if (tmo_hit) begin
                    state_next  = S_RSP;
                    status_load = 1'b1;
                    status_set  = ST_TIMEOUT;
                end
            end
            S_WR_RESP: begin
                m00_axi_bready = 1'b1;
                if (m00_axi_bvalid) begin
                    state_next  = S_RSP;
                    status_load = 1'b1;
                    status_set  = (m00_axi_bresp != 2'b00) ? ST_BUS_ERR : ST_OK;
                end else if (tmo_hit) begin
                    state_next  = S_RSP;
                    status_load = 1'b1;
                    status_set  = ST_TIMEOUT;
                end
            end
            S_RD_ADDR: begin
                m00_axi_arvalid = 1'b1;
                if (m00_axi_arready) begin
                    state_next = S_RD_DATA;
                end else if (tmo_hit) begin
                    state_next  = S_RSP;
                    status_load = 1'b1;
                    status_set  = ST_TIMEOUT;
                end
            end
            S_RD_DATA: begin
                m00_axi_rready = 1'b1;
                if (m00_axi_rvalid) begin
                    rdata_load = 1'b1;
                    if (m00_axi_rresp != 2'b00) begin
                        state_next  = S_RSP;
                        status_load = 1'b1;
                        status_set  = ST_BUS_ERR;
                    end else if (op_q != OP_POLL || poll_match) begin
                        state_next  = S_RSP;
                        status_load = 1'b1;
                    end else if (poll_cnt != POLL_MAX) begin
                        // a failed poll compare re-issues the read from the address phase
                        poll_inc   = 1'b1;
                        state_next = S_RD_ADDR;
                    end else begin
                        state_next  = S_RSP;
                        status_load = 1'b1;
                        status_set  = ST_POLL_EX;
                    end
                end else if (tmo_hit) begin
                    state_next  = S_RSP;
                    status_load = 1'b1;
                    status_set  = ST_TIMEOUT;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            mask_q       <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            poll_cnt     <= '0;
            tmo_cnt      <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            error_q      <= 1'b0;
        end else begin
            if (fifo_pop) begin
                op_q       <= head_op;
                addr_q     <= head_addr;
                wdata_q    <= head_wdata;
                wstrb_q    <= head_wstrb;
                mask_q     <= head_mask;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
                poll_cnt   <= '0;
                rsp_data_q <= '0;
            end
            if (m00_axi_awvalid && m00_axi_awready) begin
                aw_done <= 1'b1;
            end
            if (m00_axi_wvalid && m00_axi_wready) begin
                w_done <= 1'b1;
            end
            if (rdata_load) begin
                rsp_data_q <= m00_axi_rdata;
            end
            // error rises on the same edge that raises rsp_valid
            if (status_load) begin
                rsp_status_q <= status_set;
                if (status_set != ST_OK) begin
                    error_q <= 1'b1;
                end
            end
            if (poll_inc) begin
                poll_cnt <= poll_cnt + 1'b1;
            end
            if (state_next != state) begin
                tmo_cnt <= '0;
            end else if (wait_state) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_seq_master.sv
// tb/tb_axi_lite_seq_master.sv - scoreboard bench for axi_lite_seq_master with a behavioural AXI slave

module tb_axi_lite_seq_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PLIM = 3;
    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          areset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata, cmd_mask;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_status;
    logic          busy, error;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    axi_lite_seq_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(8), .POLL_LIMIT(PLIM), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .m00_axi_aclk(clk), .m00_axi_areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
        .busy(busy), .error(error),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
        .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
        .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  status;
        int          ars;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        err_model = 1'b0;
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] script_q[$];
    logic [31:0] addrs [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104};
    bit          stall_mode = 0;
    bit          random_mode = 0;
    bit          rsp_hold = 0;
    int          stall_run = 0;
    int          cyc = 0;
    int          aw_rise = 0;
    int          rsp_rise = 0;
    bit          aw_w_together = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 32'h0;
    endfunction

    // slave: error window is addr[8]=1 (SLVERR, no store); everything else is plain memory
    initial begin : slave
        bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, rst_s, prev_aw;
        bit          have_aw, have_w, b_pend, r_pend;
        int          b_wait, r_wait, aw_run;
        logic [31:0] aw_s, w_s, ar_s, aw_a, w_d, r_d;
        logic [3:0]  ws_s, w_st;
        logic [1:0]  b_r, r_r;
        prev_aw = 0; have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0; aw_run = 0;
        awready = 1; wready = 1; arready = 1; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0; rsp_ready = 1;
        forever begin
            @(negedge clk);
            rst_s = areset;
            aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
            ar_hs = arvalid && arready; r_hs = rvalid && rready;
            aw_s = awaddr; w_s = wdata; ws_s = wstrb; ar_s = araddr;
            if (awvalid) aw_run++;
            else begin
                if (prev_aw && stall_mode) begin
                    stall_run = aw_run;
                    stall_mode = 0;
                end
                aw_run = 0;
            end
            prev_aw = awvalid;
            @(posedge clk); #1;
            if (rst_s) begin
                have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
                bvalid = 0; rvalid = 0; stall_mode = 0; script_q.delete();
            end else begin
                if (b_hs) bvalid = 0;
                if (r_hs) rvalid = 0;
                if (aw_hs) begin have_aw = 1; aw_a = aw_s; end
                if (w_hs) begin have_w = 1; w_d = w_s; w_st = ws_s; end
                if (have_aw && have_w) begin
                    if (aw_a[8]) b_r = 2'b10;
                    else begin
                        b_r = 2'b00;
                        slv_mem[aw_a] = ((slv_mem.exists(aw_a) ? slv_mem[aw_a] : 32'h0) & ~strb_mask(w_st))
                                        | (w_d & strb_mask(w_st));
                    end
                    have_aw = 0; have_w = 0; b_pend = 1;
                    b_wait = random_mode ? $urandom_range(0, 3) : 0;
                end
                if (b_pend && !bvalid) begin
                    if (b_wait == 0) begin bvalid = 1; bresp = b_r; b_pend = 0; end
                    else b_wait--;
                end
                if (ar_hs) begin
                    if (script_q.size() > 0) begin r_d = script_q.pop_front(); r_r = 2'b00; end
                    else if (ar_s[8]) begin r_d = 32'h0; r_r = 2'b10; end
                    else begin r_d = slv_mem.exists(ar_s) ? slv_mem[ar_s] : 32'h0; r_r = 2'b00; end
                    r_pend = 1;
                    r_wait = random_mode ? $urandom_range(0, 3) : 0;
                end
                if (r_pend && !rvalid) begin
                    if (r_wait == 0) begin rvalid = 1; rdata = r_d; rresp = r_r; r_pend = 0; end
                    else r_wait--;
                end
            end
            awready = stall_mode ? 1'b0 : (random_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
            wready  = stall_mode ? 1'b0 : (random_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
            arready = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            rsp_ready = rsp_hold ? 1'b0 : (random_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    initial begin : monitor
        int   ar_cnt;
        bit   prev_rsp, prev_awv;
        exp_t e;
        ar_cnt = 0; prev_rsp = 0; prev_awv = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (areset) begin
                ar_cnt = 0; prev_rsp = 0; prev_awv = 0;
            end else begin
                if (awvalid && !prev_awv) begin aw_rise = cyc; aw_w_together = wvalid; end
                if (rsp_valid && !prev_rsp) rsp_rise = cyc;
                prev_awv = awvalid;
                prev_rsp = rsp_valid;
                if (arvalid && arready) ar_cnt++;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", {30'h0, rsp_status}, 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.status != 2'b00) err_model = 1'b1;
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_status", rsp_status, e.status);
                        check("ar_handshakes", ar_cnt, e.ars);
                        check("error_flag", error, err_model);
                    end
                    ar_cnt = 0;
                end
            end
        end
    end

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] m);
        bit ok;
        ok = 0;
        cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_mask = m; cmd_valid = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        cmd_valid = 0;
        if (!ok) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] m);
        exp_t        e;
        logic [31:0] v;
        if (op == 2'b00) begin
            e.data = 0; e.ars = 0;
            e.status = a[8] ? 2'b01 : 2'b00;
            if (!a[8]) model_mem[a] = (mrd(a) & ~strb_mask(s)) | (d & strb_mask(s));
        end else begin
            v = mrd(a);
            if (a[8]) begin e.data = 0; e.status = 2'b01; e.ars = 1; end
            else if (op == 2'b10 && ((v ^ d) & m) != 0) begin e.data = v; e.status = 2'b10; e.ars = PLIM + 1; end
            else begin e.data = v; e.status = 2'b00; e.ars = 1; end
        end
        exp_q.push_back(e);
        push(op, a, d, s, m);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin done = 1; break; end
        end
        if (!done) check("wait_idle_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

    initial begin : main
        int          acc;
        exp_t        e;
        logic [1:0]  op;
        logic [31:0] a, d, m;
        logic [3:0]  s;
        areset = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; cmd_mask = 0;
        repeat (3) @(posedge clk);
        #1 areset = 0;
        @(negedge clk);
        check_reset_outputs();
        check("awprot_zero", {awprot, arprot}, 0);
        @(posedge clk); #1;

        issue(2'b00, 32'h4, 32'hFFFF_FFFF, 4'hF, 32'h0);
        wait_idle();
        check("aw_w_same_cycle", aw_w_together, 1);
        check("write_latency", rsp_rise - aw_rise, 2);

        issue(2'b00, 32'h4, 32'hFFFF_FFFF, 4'hF, 32'h0);
        issue(2'b01, 32'h4, 32'h0, 4'h0, 32'h0);
        wait_idle();

        script_q = '{32'h0, 32'h0, 32'h0, 32'h1};
        e.data = 32'h1; e.status = 2'b00; e.ars = 4;
        exp_q.push_back(e);
        push(2'b10, 32'h0, 32'h1, 4'h0, 32'h1);
        wait_idle();

        issue(2'b10, 32'h0, 32'h1, 4'h0, 32'h1);
        wait_idle();
        check("error_sticky", error, 1);

        stall_mode = 1;
        e.data = 0; e.status = 2'b11; e.ars = 0;
        exp_q.push_back(e);
        push(2'b00, 32'h8, 32'hAAAA_5555, 4'hF, 32'h0);
        issue(2'b00, 32'h8, 32'h1234_5678, 4'hF, 32'h0);
        issue(2'b01, 32'h8, 32'h0, 4'h0, 32'h0);
        wait_idle();
        check("timeout_aw_cycles", stall_run, TMO);

        random_mode = 1;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = addrs[$urandom_range(0, 5)];
            d  = $urandom;
            s  = 4'($urandom_range(1, 15));
            m  = $urandom;
            if (op == 2'b10 && $urandom_range(0, 1) == 1) d = mrd(a) ^ (~m & $urandom);
            issue(op, a, d, s, m);
        end
        wait_idle();
        random_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        rsp_hold = 1; stall_mode = 1; acc = 0;
        cmd_op = 2'b00; cmd_addr = 32'h4; cmd_wdata = 32'h5A5A_5A5A; cmd_wstrb = 4'hF; cmd_mask = 0;
        cmd_valid = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cmd_ready) break;
            acc++;
            @(posedge clk); #1;
        end
        cmd_valid = 0;
        check("fifo_fill_accepted", acc, 9);
        check("fifo_full_busy", busy, 1);
        check("mid_write_awvalid", awvalid, 1);
        @(posedge clk); #1;
        areset = 1;
        exp_q.delete();
        err_model = 0;
        @(posedge clk); #1;
        areset = 0;
        rsp_hold = 0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;

        issue(2'b00, 32'hC, 32'hCAFE_F00D, 4'h3, 32'h0);
        issue(2'b01, 32'hC, 32'h0, 4'h0, 32'h0);
        issue(2'b10, 32'hC, mrd(32'hC), 4'h0, 32'hFFFF_FFFF);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
